instr_fetch_unit: RTL and testbench

Fetch stage of the pipelined 64-bit ARM datapath. It is the initiator side of the instruction-ROM interface: it owns the PC, drives the byte address to the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. It also handles stall, flush and branch redirect requests from the hazard and branch logic.

---
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-ROM address and captures IF/ID.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned IMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [63:0] pc,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        fetch_fault
);

    logic [63:0] pc_q, pc_d;
    logic [63:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;

    // Qualifiers that collapse to constant 0 when the bounds check is compiled out.
    logic        in_fault;
    logic        fetch_oob;
    logic        target_oob;

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [0:0] {StRun, StFault} state_e;
    state_e state_q, state_d;

    // 65-bit sums so a PC near 2^64 cannot wrap back into range.
    assign in_fault   = (state_q == StFault);
    assign fetch_oob  = ({1'b0, pc_q} + 65'd3) >= 65'(IMEM_SIZE);
    assign target_oob = ({1'b0, br_target} + 65'd3) >= 65'(IMEM_SIZE);

    always_comb begin
        state_d = state_q;
        if (br_taken) begin
            if (!(in_fault && target_oob)) begin
                state_d = StRun;
            end
        end else if (!in_fault && !stall && fetch_oob) begin
            state_d = StFault;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign in_fault   = 1'b0;
    assign fetch_oob  = 1'b0;
    assign target_oob = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (br_taken || in_fault || (!stall && (flush || fetch_oob)) || (stall && flush)) begin
            id_pc_d    = 64'd0;
            id_instr_d = 32'd0;
            id_valid_d = 1'b0;
        end
        if (br_taken) begin
            if (!(in_fault && target_oob)) begin
                pc_d = {br_target[63:2], 2'b00};
            end
        end else if (!in_fault && !stall && !fetch_oob) begin
            pc_d = pc_q + 64'd4;
            if (!flush) begin
                id_pc_d    = pc_q;
                id_instr_d = imem_instruction;
                id_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= 64'd0;
            id_instr_q <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_address      = pc_q;
    assign pc                = pc_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_instruction = id_instr_q;
    assign if_id_valid       = id_valid_q;
    assign fetch_fault       = in_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; ROM word at byte address A is 0xC0DE0000 + A[15:2].
// Define FETCH_BOUNDS_CHECK_EN to check the fault behaviour of the bounds-checked build.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic [63:0] pc;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        fetch_fault;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    instr_fetch_unit #(
        .RESET_PC (64'd0),
        .IMEM_SIZE(1024)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .pc               (pc),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid),
        .fetch_fault      (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] addr);
        return 32'hC0DE_0000 + {18'd0, addr[15:2]};
    endfunction

    assign imem_instruction = rom_word(imem_address);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full visible state: pc, IF/ID triple, fault flag, and address mirroring pc.
    task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic [63:0] e_idpc,
                           input logic [31:0] e_ins, input logic e_v, input logic e_f);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".addr"}, imem_address, e_pc);
        chk({tag, ".id_pc"}, if_id_pc, e_idpc);
        chk({tag, ".id_ins"}, {32'd0, if_id_instruction}, {32'd0, e_ins});
        chk({tag, ".id_v"}, {63'd0, if_id_valid}, {63'd0, e_v});
        chk({tag, ".fault"}, {63'd0, fetch_fault}, {63'd0, e_f});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 64'd0;
        step();
        chk_all("reset", 64'd0, 64'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Free run
        step(); chk_all("run0", 64'd4, 64'd0, 32'hC0DE_0000, 1'b1, 1'b0);
        step(); chk_all("run1", 64'd8, 64'd4, 32'hC0DE_0001, 1'b1, 1'b0);

        // Stall two cycles at pc=8
        stall = 1'b1;
        step(); chk_all("stall0", 64'd8, 64'd4, 32'hC0DE_0001, 1'b1, 1'b0);
        step(); chk_all("stall1", 64'd8, 64'd4, 32'hC0DE_0001, 1'b1, 1'b0);
        stall = 1'b0;
        step(); chk_all("release", 64'd12, 64'd8, 32'hC0DE_0002, 1'b1, 1'b0);
        step(); chk_all("run3", 64'd16, 64'd12, 32'hC0DE_0003, 1'b1, 1'b0);

        // Flush alone
        flush = 1'b1;
        step(); chk_all("flush", 64'd20, 64'd0, 32'd0, 1'b0, 1'b0);
        flush = 1'b0;

        // Branch overrides stall and flush; low bits masked
        br_taken = 1'b1; br_target = 64'h2F; stall = 1'b1; flush = 1'b1;
        step(); chk_all("br_mask", 64'h2C, 64'd0, 32'd0, 1'b0, 1'b0);
        br_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        step(); chk_all("br_fetch", 64'h30, 64'h2C, 32'hC0DE_000B, 1'b1, 1'b0);

        // Stall with flush: pc holds, IF/ID bubbles
        stall = 1'b1; flush = 1'b1;
        step(); chk_all("stall_flush", 64'h30, 64'd0, 32'd0, 1'b0, 1'b0);
        stall = 1'b0; flush = 1'b0;
        step(); chk_all("resume", 64'h34, 64'h30, 32'hC0DE_000C, 1'b1, 1'b0);

        // Asynchronous reset between edges
        br_taken = 1'b1; br_target = 64'h40;
        step(); chk_all("br40", 64'h40, 64'd0, 32'd0, 1'b0, 1'b0);
        br_taken = 1'b0;
        step(); chk_all("run40", 64'h44, 64'h40, 32'hC0DE_0010, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 64'd0, 64'd0, 32'd0, 1'b0, 1'b0);
        step(); chk_all("rst_hold", 64'd0, 64'd0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(); chk_all("post_rst", 64'd4, 64'd0, 32'hC0DE_0000, 1'b1, 1'b0);

`ifndef FETCH_BOUNDS_CHECK_EN
        // PC wraps modulo 2^64
        br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFE;
        step(); chk_all("br_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 32'd0, 1'b0, 1'b0);
        br_taken = 1'b0;
        step(); chk_all("wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DE_3FFF, 1'b1, 1'b0);
`endif

        // Top of ROM
        br_taken = 1'b1; br_target = 64'd1020;
        step(); chk_all("br1020", 64'd1020, 64'd0, 32'd0, 1'b0, 1'b0);
        br_taken = 1'b0;
        step(); chk_all("fetch1020", 64'd1024, 64'd1020, 32'hC0DE_00FF, 1'b1, 1'b0);
`ifdef FETCH_BOUNDS_CHECK_EN
        step(); chk_all("fault", 64'd1024, 64'd0, 32'd0, 1'b0, 1'b1);
        step(); chk_all("fault_hold", 64'd1024, 64'd0, 32'd0, 1'b0, 1'b1);
        br_taken = 1'b1; br_target = 64'd2000;
        step(); chk_all("fault_bad_br", 64'd1024, 64'd0, 32'd0, 1'b0, 1'b1);
        br_target = 64'h10;
        step(); chk_all("fault_clr", 64'h10, 64'd0, 32'd0, 1'b0, 1'b0);
`else
        step(); chk_all("no_check", 64'd1028, 64'd1024, 32'hC0DE_0100, 1'b1, 1'b0);
        br_taken = 1'b1; br_target = 64'h10;
        step(); chk_all("br10", 64'h10, 64'd0, 32'd0, 1'b0, 1'b0);
`endif
        br_taken = 1'b0;
        step(); chk_all("run10", 64'h14, 64'h10, 32'hC0DE_0004, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
